wfg_wb_decode: RTL and testbench
================================

Name: wfg_wb_decode

Overview:
- Parametrised Wishbone classic-cycle address decoder and response router between the top-level Wishbone slave port and NSLAVES peripheral blocks (core, stimuli, drivers).
- Replaces hand-written per-peripheral select, ack-OR and read-mux logic with a registered, FSM-based decoder.
- Adds bus-error responses for unmapped pages, a slave-response timeout, and a sticky error-address capture register.

Parameters:
- BUSW, 32, data/address bus width in bits.
- NSLAVES, 4, number of peripherals; range 1..16.
- PAGE_LSB, 4, bits of in-page offset; page = adr[BUSW-1:PAGE_LSB].
- BASE_PAGE, 1, page of slave 0; slave i sits at page BASE_PAGE+i. Must be >=1 because page 0 is never mapped; elaboration-time assertion.
- TIMEOUT, 255, maximum cycles spent waiting for a slave ack; must be >=1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i  in  1  master cycle
- wbs_stb_i  in  1  master strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  BUSW/8  byte selects
- wbs_adr_i  in  BUSW  byte address
- wbs_dat_i  in  BUSW  write data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_err_o  out  1  transfer error
- wbs_dat_o  out  BUSW  read data
- s_stb_o  out  NSLAVES  per-slave strobe, one-hot or zero
- s_cyc_o  out  1  shared cycle
- s_we_o  out  1  latched write enable
- s_sel_o  out  BUSW/8  latched byte selects
- s_adr_o  out  PAGE_LSB  latched in-page offset
- s_dat_o  out  BUSW  latched write data
- s_ack_i  in  NSLAVES  per-slave ack
- s_dat_i  in  NSLAVES*BUSW  per-slave read data; slave i occupies bits [i*BUSW +: BUSW]
- err_valid_o  out  1  sticky error flag
- err_code_o  out  2  01 = decode miss, 10 = timeout
- err_adr_o  out  BUSW  address of the last failed access
- err_clr_i  in  1  clears err_valid_o

Behaviour:
- Single clock wb_clk_i. Synchronous active-high reset wb_rst_i; takes effect on the next clock edge regardless of state.
- Reset values: state IDLE; every output 0 (including s_stb_o, s_cyc_o, wbs_ack_o, wbs_err_o, wbs_dat_o and all err_* outputs); timer 0.
- FSM states: IDLE, BUSY, RESP, ERR.
- IDLE, on cyc&stb:
  - Compute page. Hit when BASE_PAGE <= page <= BASE_PAGE+NSLAVES-1; index = page-BASE_PAGE.
  - On hit: latch index, we, sel, offset and write data; go to BUSY.
  - On miss: go to ERR.
- BUSY:
  - s_stb_o[index]=1 and s_cyc_o=1, both registered outputs.
  - On s_ack_i[index]: capture that slave's read data into wbs_dat_o; go to RESP.
  - Acks from non-selected slaves are ignored.
- RESP: wbs_ack_o=1 for exactly one cycle; s_stb_o=0; then IDLE.
- ERR:
  - wbs_err_o=1 for exactly one cycle.
  - err_valid_o<=1; err_adr_o<=latched address; err_code_o set.
  - Then IDLE.
- Latency: master strobe at edge N gives slave strobe at N+1. A slave ack at edge K gives master ack at K+1. A decode miss gives wbs_err_o at N+1.
- Abort: cyc low in BUSY returns to IDLE on the next edge with no ack/err and s_stb_o cleared. Abort wins over a same-cycle slave ack.
- Timer:
  - Cleared on entry to BUSY; increments each BUSY cycle.
  - When the timer reaches TIMEOUT without an ack, go to ERR with code 10.
  - A slave ack in the same cycle as expiry wins (RESP).
- wbs_dat_o holds its last value outside RESP. Writes do not modify it.
- Error register:
  - err_clr_i clears err_valid_o.
  - A new error in the same cycle as err_clr_i wins (flag stays set, fields updated).
  - A later error overwrites code and address.
- Only one transfer is outstanding. A new request is accepted only in IDLE, so back-to-back transfers are spaced by at least one IDLE cycle.

Optional Feature:
- Macro: WFG_WB_DECODE_TIMEOUT_EN.
- Defined: timer and timeout-to-ERR path present as described above.
- Undefined: no timer logic; BUSY waits indefinitely for an ack or cyc drop; err_code_o never reports 10.

Decomposition:
- Package wfg_wb_decode_pkg:
  - state enum typedef (IDLE, BUSY, RESP, ERR);
  - err_code typedef with constants ERR_NONE=00, ERR_DECODE=01, ERR_TIMEOUT=10.
- Sub-module wfg_wb_timeout_cnt: clear/enable counter with a TIMEOUT parameter and an expired output; instantiated only under WFG_WB_DECODE_TIMEOUT_EN.

Test Plan:
- Write 0xDEADBEEF to 0x24 (NSLAVES=4) -> s_stb_o=0010 one cycle after stb, s_adr_o=4, s_dat_o=0xDEADBEEF; slave 1 acks -> wbs_ack_o one cycle later, pulse width 1.
- Read 0x30 with slave 2 returning 0x12345678 and slave 0 raising a stray ack -> wbs_dat_o=0x12345678, slave 0 ack ignored.
- Access 0x00 and 0x50 -> wbs_err_o pulse at N+1, no s_stb_o, err_code_o=01, err_adr_o=0x50, err_valid_o=1 until err_clr_i.
- TIMEOUT=8 with a non-responding slave -> wbs_err_o after 8 BUSY cycles, err_code_o=10. Repeat with the ack on the expiry cycle -> wbs_ack_o, no error.
- cyc dropped mid-BUSY with a same-cycle ack -> no wbs_ack_o, FSM back in IDLE. Reset asserted in BUSY -> all outputs 0 next edge.
- err_clr_i coincident with a new decode miss -> err_valid_o stays 1 and err_adr_o is updated.

Source files
------------

// File: rtl/wfg_wb_decode_pkg.sv
// rtl/wfg_wb_decode_pkg.sv - shared state and error-code types for the wishbone page decoder
package wfg_wb_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_DECODE  = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_e;

endpackage

// File: rtl/wfg_wb_timeout_cnt.sv
// rtl/wfg_wb_timeout_cnt.sv - clear/enable cycle counter flagging the TIMEOUT-th enabled cycle
module wfg_wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Value k during the (k+1)-th enabled cycle, so expiry lands on cycle TIMEOUT.
  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wfg_wb_decode.sv
// rtl/wfg_wb_decode.sv - registered wishbone page decoder with bus-error and sticky error capture
// Slave-response timeout is built only when WFG_WB_DECODE_TIMEOUT_EN is defined.
module wfg_wb_decode
  import wfg_wb_decode_pkg::*;
#(
  parameter int BUSW      = 32,
  parameter int NSLAVES   = 4,
  parameter int PAGE_LSB  = 4,
  parameter int BASE_PAGE = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [BUSW/8-1:0]       wbs_sel_i,
  input  logic [BUSW-1:0]         wbs_adr_i,
  input  logic [BUSW-1:0]         wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [BUSW-1:0]         wbs_dat_o,
  output logic [NSLAVES-1:0]      s_stb_o,
  output logic                    s_cyc_o,
  output logic                    s_we_o,
  output logic [BUSW/8-1:0]       s_sel_o,
  output logic [PAGE_LSB-1:0]     s_adr_o,
  output logic [BUSW-1:0]         s_dat_o,
  input  logic [NSLAVES-1:0]      s_ack_i,
  input  logic [NSLAVES*BUSW-1:0] s_dat_i,
  output logic                    err_valid_o,
  output logic [1:0]              err_code_o,
  output logic [BUSW-1:0]         err_adr_o,
  input  logic                    err_clr_i
);

  localparam int PW = BUSW - PAGE_LSB;
  localparam int SW = BUSW / 8;

  generate
    if (BASE_PAGE < 1 || NSLAVES < 1 || NSLAVES > 16 || TIMEOUT < 1) begin : g_param_chk
      $error("wfg_wb_decode: illegal parameter set");
    end
  endgenerate

  state_e              r_state, w_next;
  logic [NSLAVES-1:0]  w_hit_oh;
  logic [BUSW-1:0]     w_rd_dat;
  logic                w_req, w_ack, w_expired;

  logic                r_ack, r_err, r_cyc, r_we, r_err_valid;
  logic [NSLAVES-1:0]  r_stb;
  logic [SW-1:0]       r_sel;
  logic [PAGE_LSB-1:0] r_off;
  logic [BUSW-1:0]     r_wdat, r_rdat, r_adr, r_err_adr;
  err_code_e           r_err_code;

  assign w_req = wbs_cyc_i & wbs_stb_i;
  // r_stb is only non-zero in BUSY, so it doubles as the ack/data select.
  assign w_ack = |(s_ack_i & r_stb);

  always_comb begin
    w_hit_oh = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      w_hit_oh[i] = (wbs_adr_i[BUSW-1:PAGE_LSB] == PW'(BASE_PAGE + i));
    end
  end

  always_comb begin
    w_rd_dat = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (r_stb[i]) w_rd_dat = w_rd_dat | s_dat_i[i*BUSW +: BUSW];
    end
  end

`ifdef WFG_WB_DECODE_TIMEOUT_EN
  wfg_wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_clr     (r_state != ST_BUSY),
    .i_en      (r_state == ST_BUSY),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Abort beats a same-cycle ack, and an ack beats a same-cycle expiry.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req) w_next = (|w_hit_oh) ? ST_BUSY : ST_ERR;
      ST_BUSY: begin
        if (!wbs_cyc_i)     w_next = ST_IDLE;
        else if (w_ack)     w_next = ST_RESP;
        else if (w_expired) w_next = ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_off       <= '0;
      r_wdat      <= '0;
      r_adr       <= '0;
      r_rdat      <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_adr   <= '0;
    end else begin
      r_ack <= (w_next == ST_RESP);
      r_err <= (w_next == ST_ERR);
      r_cyc <= (w_next == ST_BUSY);
      if (w_next != ST_BUSY) r_stb <= '0;
      if (r_state == ST_IDLE && w_next == ST_BUSY) begin
        r_stb  <= w_hit_oh;
        r_we   <= wbs_we_i;
        r_sel  <= wbs_sel_i;
        r_off  <= wbs_adr_i[PAGE_LSB-1:0];
        r_wdat <= wbs_dat_i;
        r_adr  <= wbs_adr_i;
      end
      if (r_state == ST_BUSY && w_next == ST_RESP && !r_we) r_rdat <= w_rd_dat;
      if (w_next == ST_ERR) begin
        r_err_valid <= 1'b1;
        r_err_adr   <= (r_state == ST_IDLE) ? wbs_adr_i : r_adr;
        r_err_code  <= (r_state == ST_IDLE) ? ERR_DECODE : ERR_TIMEOUT;
      end else if (err_clr_i) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_err_o   = r_err;
  assign wbs_dat_o   = r_rdat;
  assign s_stb_o     = r_stb;
  assign s_cyc_o     = r_cyc;
  assign s_we_o      = r_we;
  assign s_sel_o     = r_sel;
  assign s_adr_o     = r_off;
  assign s_dat_o     = r_wdat;
  assign err_valid_o = r_err_valid;
  assign err_code_o  = r_err_code;
  assign err_adr_o   = r_err_adr;

endmodule

// File: tb/tb_wfg_wb_decode.sv
// tb/tb_wfg_wb_decode.sv - scoreboard bench for wfg_wb_decode (NSLAVES=4, TIMEOUT=8)
module tb_wfg_wb_decode;

  localparam int BUSW = 32;
  localparam int NS   = 4;
  localparam int TMO  = 8;
`ifdef WFG_WB_DECODE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int K_ACK = 0, K_ERR = 1, K_ABORT = 2;

  typedef struct {
    int          kind;
    logic [1:0]  code;
    logic [31:0] rdat;
    logic [31:0] adr;
    int          lat;
  } sb_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = '0;
  logic [31:0]       adr = '0, wdat = '0;
  logic              ack_o, err_o;
  logic [31:0]       dat_o;
  logic [NS-1:0]     s_stb;
  logic              s_cyc, s_we;
  logic [3:0]        s_sel, s_adr;
  logic [31:0]       s_dat_o;
  logic [NS-1:0]     s_ack = '0;
  logic [NS*32-1:0]  s_dat = '0;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [31:0]       err_adr;
  logic              err_clr = 1'b0;

  sb_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd  = '0;

  always #5 clk = ~clk;

  wfg_wb_decode #(.BUSW(BUSW), .NSLAVES(NS), .PAGE_LSB(4), .BASE_PAGE(1), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack_o), .wbs_err_o(err_o), .wbs_dat_o(dat_o),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .err_valid_o(err_valid), .err_code_o(err_code), .err_adr_o(err_adr),
    .err_clr_i(err_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int ack_dly, input int abort_at, input bit stray, input logic [31:0] rdat);
    sb_t e;
    int  page, idx, n, b;
    bit  hit, done, aborted;
    page = int'(a >> 4);
    hit  = (page >= 1) && (page <= NS);
    idx  = page - 1;
    e.adr = a;
    e.code = 2'b00;
    if (!hit) begin
      e.kind = K_ERR; e.code = 2'b01; e.lat = 1;
    end else if (abort_at > 0) begin
      e.kind = K_ABORT; e.lat = abort_at + 1;
    end else if (TMO_EN && (ack_dly < 0 || ack_dly > TMO)) begin
      e.kind = K_ERR; e.code = 2'b10; e.lat = TMO + 1;
    end else begin
      e.kind = K_ACK; e.lat = ack_dly + 1;
    end
    if (e.kind == K_ACK && !w) last_rd = rdat;
    e.rdat = last_rd;
    sb.push_back(e);

    for (int k = 0; k < NS; k++) s_dat[k*32 +: 32] = 32'hC0DE0000 | k;
    if (hit) s_dat[idx*32 +: 32] = rdat;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = w ? 4'b0011 : 4'hF;
    n = 0; b = 0; done = 0; aborted = 0;
    while (!done && n < 40) begin
      tick();
      n++;
      err_clr = 1'b0;
      s_ack = '0;
      if (ack_o || err_o || aborted) begin
        e = sb.pop_front();
        check("resp_kind", {ack_o, err_o}, {e.kind == K_ACK, e.kind == K_ERR});
        check("latency", n, e.lat);
        check("stb_clear", s_stb, 0);
        if (e.kind == K_ACK) check("rdata", dat_o, e.rdat);
        if (e.kind == K_ERR) begin
          check("err_code", err_code, e.code);
          check("err_adr", err_adr, e.adr);
          check("err_valid", err_valid, 1);
        end
        done = 1;
      end else if (hit) begin
        b++;
        if (b == 1) begin
          check("s_stb", s_stb, 64'(1) << idx);
          check("s_ctl", {s_cyc, s_we, s_sel, s_adr}, {1'b1, w, (w ? 4'b0011 : 4'hF), a[3:0]});
          if (w) check("s_dat", s_dat_o, d);
        end
        if (b == ack_dly) s_ack[idx] = 1'b1;
        if (stray && b == 1) s_ack[0] = 1'b1;
        if (b == abort_at) begin
          cyc = 1'b0; stb = 1'b0; aborted = 1;
        end
      end
      if (done) begin
        cyc = 1'b0; stb = 1'b0;
      end
    end
    if (!done) check("xfer_done", 0, 1);
    cyc = 1'b0; stb = 1'b0; s_ack = '0;
    tick();
    check("pulse_width", {ack_o, err_o, s_cyc}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_bus", {ack_o, err_o, s_stb, s_cyc, s_we, s_sel, s_adr, err_valid, err_code}, 0);
    check("rst_data", {dat_o, s_dat_o}, 0);
    check("rst_err_adr", err_adr, 0);
    tick();

    xfer(32'h24, 1'b1, 32'hDEADBEEF, 2, 0, 0, 32'h0);
    xfer(32'h30, 1'b0, 32'h0, 3, 0, 1, 32'h12345678);
    xfer(32'h10, 1'b1, 32'h55AA55AA, 1, 0, 0, 32'h0);
    xfer(32'h4C, 1'b0, 32'h0, 1, 0, 0, 32'hA5A55A5A);

    xfer(32'h00, 1'b0, 32'h0, 1, 0, 0, 32'h0);
    xfer(32'h50, 1'b1, 32'h1, 1, 0, 0, 32'h0);
    tick(); tick();
    check("err_sticky", {err_valid, err_code, err_adr}, {1'b1, 2'b01, 32'h50});
    err_clr = 1'b1;
    xfer(32'h64, 1'b0, 32'h0, 1, 0, 0, 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", {err_valid, err_adr}, {1'b0, 32'h64});

`ifdef WFG_WB_DECODE_TIMEOUT_EN
    xfer(32'h28, 1'b0, 32'h0, -1, 0, 0, 32'h0);
`else
    xfer(32'h28, 1'b0, 32'h0, 20, 0, 0, 32'h0BADCAFE);
    check("no_timeout_err", err_valid, 0);
`endif
    xfer(32'h18, 1'b0, 32'h0, TMO, 0, 0, 32'h0F0F1234);

    xfer(32'h34, 1'b0, 32'h0, 2, 2, 0, 32'hFFFF0000);
    xfer(32'h44, 1'b0, 32'h0, 1, 0, 0, 32'h13572468);

    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h14; wdat = 32'h77;
    tick();
    check("busy_pre_rst", s_stb, 4'b0001);
    rst = 1'b1;
    tick();
    check("rst_busy_bus", {ack_o, err_o, s_stb, s_cyc, s_we, s_sel, s_adr, err_valid, err_code}, 0);
    check("rst_busy_data", {dat_o, s_dat_o, err_adr}, 0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
